// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants for the I2C register-file target
package i2c_pkg;

    localparam int STATE_W    = 4;
    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_CNT_W = 2;

    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;
    typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - scl/sda sampling, edge and START/STOP detection (I2C_INPUT_SYNC_EN adds 2-flop synchronizers)
module i2c_bus_monitor (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_s;
    logic sda_s;
    logic scl_q;
    logic sda_q;

`ifdef I2C_INPUT_SYNC_EN
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;

    // Two-stage synchronizers; reset to the idle (released) bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`else
    assign scl_s = scl_i;
    assign sda_s = sda_i;
`endif

    // Previous-cycle samples; idle level avoids a false edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_q;
    assign scl_fall_o = ~scl_s & scl_q;
    assign start_o    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_o     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_regfile_target.sv
// rtl/i2c_regfile_target.sv - I2C target with a bank of 32-bit registers (I2C_INPUT_SYNC_EN selects input synchronizers)
module i2c_regfile_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         NUM_REGS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_out,
    output logic        sda_in,
    input  logic [7:0]  host_addr,
    output logic [31:0] host_rdata,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic        busy
);

    localparam int         IDXW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_monitor u_bus_monitor (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl),
        .sda_i      (sda_out),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_t      state_q,    state_d;
    bit_cnt_t    bit_cnt_q,  bit_cnt_d;
    byte_cnt_t   byte_cnt_q, byte_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic [31:0] shadow_q,   shadow_d;
    logic [7:0]  reg_q,      reg_d;
    logic        rw_q,       rw_d;
    logic        sda_in_q,   sda_in_d;
    logic        busy_q,     busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [7:0]  wr_addr_q,  wr_addr_d;
    logic        commit;

    logic [31:0] regs_q [NUM_REGS];

    // Host-side combinational read; indices past the bank read as zero.
    always_comb begin
        host_rdata = '0;
        if ({1'b0, host_addr} < NUM_REGS_L) begin
            host_rdata = regs_q[host_addr[IDXW-1:0]];
        end
    end

    // Protocol FSM: bits are taken on scl rise, sda_in is updated on scl fall
    // so the new level appears during the following low phase.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        reg_d       = reg_q;
        rw_d        = rw_q;
        sda_in_d    = sda_in_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        commit      = 1'b0;

        if (stop_det) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            sda_in_d   = NACK;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else if (start_det) begin
            state_d    = ST_ADDR;
            busy_d     = 1'b0;
            sda_in_d   = NACK;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG: begin
                    if (scl_fall) begin
                        sda_in_d = NACK;
                    end else if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_REG_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            sda_in_d = ACK;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_rise) begin
                        state_d = ST_REG;
                    end
                end
                ST_REG_ACK: begin
                    if (scl_fall) begin
                        if ({1'b0, shift_q} < NUM_REGS_L) begin
                            sda_in_d = ACK;
                            reg_d    = shift_q;
                            shadow_d = regs_q[shift_q[IDXW-1:0]];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_rise) begin
                        state_d    = (rw_q == RW_READ) ? ST_RDATA : ST_WDATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                ST_WDATA: begin
                    if (scl_fall) begin
                        sda_in_d = NACK;
                    end else if (scl_rise) begin
                        shadow_d  = {shadow_q[30:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_in_d = ACK;
                        if (byte_cnt_q == 2'd3) begin
                            commit      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = reg_q;
                        end
                    end else if (scl_rise) begin
                        if (byte_cnt_q == 2'd3) begin
                            state_d = ST_IGNORE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    // shadow_q[31] always holds the bit due on the next low phase.
                    if (scl_fall) begin
                        sda_in_d = shadow_q[31];
                    end else if (scl_rise) begin
                        shadow_d  = {shadow_q[30:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RDATA_ACK;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_in_d = NACK;
                    end else if (scl_rise) begin
                        if (sda_s == ACK && byte_cnt_q != 2'd3) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = ST_RDATA;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_IGNORE: begin
                    if (scl_fall) begin
                        sda_in_d = NACK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            shadow_q    <= '0;
            reg_q       <= '0;
            rw_q        <= RW_WRITE;
            sda_in_q    <= 1'b1;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            reg_q       <= reg_d;
            rw_q        <= rw_d;
            sda_in_q    <= sda_in_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    // Register bank: a word is committed only once all four bytes arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[reg_q[IDXW-1:0]] <= shadow_q;
        end
    end

    assign sda_in    = sda_in_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_i2c_regfile_target.sv
// tb/tb_i2c_regfile_target.sv - scoreboard bench for i2c_regfile_target
module tb_i2c_regfile_target;

    localparam logic [6:0] TGT   = 7'h50;
    localparam int         NREGS = 16;
    localparam int         H     = 5;

    logic        clk;
    logic        rst;
    logic        scl;
    logic        sda_out;
    logic        sda_in;
    logic [7:0]  host_addr;
    logic [31:0] host_rdata;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic        busy;

    i2c_regfile_target #(.TARGET_ADDR(TGT), .NUM_REGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda_out    (sda_out),
        .sda_in     (sda_in),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    logic [31:0] mregs [NREGS];
    logic        exp_bit_q [$];
    string       exp_nm_q  [$];
    logic [7:0]  exp_wr_q  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_bit(input logic v, input string nm);
        exp_bit_q.push_back(v);
        exp_nm_q.push_back(nm);
    endtask

    // Samples sda_in in the middle of every scl high phase.
    task automatic mon_bits();
        forever begin
            @(posedge scl);
            repeat (2) @(negedge clk);
            if (exp_bit_q.size() == 0) begin
                chk("unexpected scl pulse", 32'd1, 32'd0);
            end else begin
                chk(exp_nm_q.pop_front(), {31'd0, sda_in}, {31'd0, exp_bit_q.pop_front()});
            end
        end
    endtask

    task automatic mon_wr();
        forever begin
            @(negedge clk);
            if (wr_strobe) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected wr_strobe", 32'd1, 32'd0);
                end else begin
                    chk("wr_addr", {24'd0, wr_addr}, {24'd0, exp_wr_q.pop_front()});
                end
            end
        end
    endtask

    task automatic clk_bit(input logic b);
        repeat (2) @(negedge clk);
        sda_out = b;
        repeat (H - 2) @(negedge clk);
        scl = 1'b1;
        repeat (H) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        scl = 1'b1;
        sda_out = 1'b1;
        repeat (H) @(negedge clk);
        sda_out = 1'b0;
        repeat (H) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        repeat (2) @(negedge clk);
        sda_out = 1'b0;
        repeat (H - 2) @(negedge clk);
        push_bit(1'b1, "stop clock released");
        scl = 1'b1;
        repeat (H) @(negedge clk);
        sda_out = 1'b1;
        repeat (H) @(negedge clk);
        chk("busy after stop", {31'd0, busy}, 32'd0);
        chk("sda_in after stop", {31'd0, sda_in}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input string nm);
        for (int i = 7; i >= 0; i--) begin
            push_bit(1'b1, "released while master drives");
            clk_bit(b[i]);
        end
        push_bit(ack_exp, nm);
        clk_bit(1'b1);
    endtask

    task automatic write_txn(input logic [6:0] a7, input logic [7:0] r, input logic [31:0] d, input int nbytes);
        logic ok_a;
        logic ok_r;
        ok_a = (a7 == TGT);
        ok_r = ok_a && (r < 8'(NREGS));
        start_cond();
        send_byte({a7, 1'b0}, ok_a ? 1'b0 : 1'b1, "write addr ack");
        chk("busy after write addr", {31'd0, busy}, {31'd0, ok_a});
        send_byte(r, ok_r ? 1'b0 : 1'b1, "write reg ack");
        for (int k = 0; k < nbytes; k++) begin
            if (ok_r && k == 3) begin
                exp_wr_q.push_back(r);
                mregs[r[3:0]] = d;
            end
            send_byte(8'(d >> (24 - 8 * k)), ok_r ? 1'b0 : 1'b1, "write data ack");
        end
        stop_cond();
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        chk("sda_in after mid rst", {31'd0, sda_in}, 32'd1);
        chk("busy after mid rst", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_txn(input logic [6:0] a7, input logic [7:0] r, input int rst_at);
        logic        ok_a;
        logic        ok_r;
        logic        alive;
        logic [31:0] word;
        ok_a  = (a7 == TGT);
        ok_r  = ok_a && (r < 8'(NREGS));
        alive = 1'b1;
        word  = mregs[r[3:0]];
        start_cond();
        send_byte({a7, 1'b1}, ok_a ? 1'b0 : 1'b1, "read addr ack");
        chk("busy after read addr", {31'd0, busy}, {31'd0, ok_a});
        send_byte(r, ok_r ? 1'b0 : 1'b1, "read reg ack");
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                if (k * 8 + i == rst_at) begin
                    pulse_rst();
                    alive = 1'b0;
                end
                push_bit((alive && ok_r) ? word[31 - (k * 8 + i)] : 1'b1, "read data bit");
                clk_bit(1'b1);
            end
            push_bit(1'b1, "released during master ack");
            clk_bit(k == 3);
        end
        stop_cond();
    endtask

    task automatic host_check();
        for (int i = 0; i < NREGS; i++) begin
            host_addr = 8'(i);
            #1;
            chk("host_rdata", host_rdata, mregs[i]);
        end
        host_addr = 8'h20;
        #1;
        chk("host_rdata out of range 0x20", host_rdata, 32'd0);
        host_addr = 8'hFF;
        #1;
        chk("host_rdata out of range 0xFF", host_rdata, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] a7;
        logic [7:0] r;
        total = 0;
        bad = 0;
        rst = 1'b1;
        scl = 1'b1;
        sda_out = 1'b1;
        host_addr = 8'd0;
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset sda_in", {31'd0, sda_in}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("reset wr_addr", {24'd0, wr_addr}, 32'd0);
        host_check();

        fork
            mon_bits();
            mon_wr();
        join_none

        write_txn(7'h50, 8'd3, 32'hDEADBEEF, 4);
        host_check();
        read_txn(7'h50, 8'd3, -1);
        write_txn(7'h51, 8'd3, 32'h12345678, 4);
        host_check();
        write_txn(7'h50, 8'h20, 32'h0BADF00D, 4);
        write_txn(7'h50, 8'd5, 32'hA5A55A5A, 2);
        host_check();
        write_txn(7'h50, 8'd5, 32'hCAFEF00D, 4);
        host_check();
        read_txn(7'h50, 8'd3, 12);
        host_check();
        read_txn(7'h50, 8'd3, -1);

        for (int n = 0; n < 20; n++) begin
            a7 = ($urandom_range(0, 7) == 0) ? 7'h51 : TGT;
            r  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                read_txn(a7, r, -1);
            end else begin
                write_txn(a7, r, $urandom, $urandom_range(1, 4));
            end
        end
        host_check();

        repeat (20) @(negedge clk);
        chk("bit scoreboard drained", exp_bit_q.size(), 32'd0);
        chk("write scoreboard drained", exp_wr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
